// File: rtl/ifft8_symbol_ctrl.sv
// ifft8_symbol_ctrl: sequencer around an 8-point IFFT core.
// Collects 8 complex 8-bit subcarriers from a valid/ready stream, presents them
// in parallel to the core, runs the core start/done handshake under a watchdog,
// captures the bit-reversed 16-bit results and streams them out in natural order.
module ifft8_symbol_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic signed [7:0]  s_i,
    input  logic signed [7:0]  s_q,
    output logic               core_start,
    output logic [127:0]       core_in,
    input  logic               core_done,
    input  logic [255:0]       core_out,
    output logic               m_valid,
    input  logic               m_ready,
    output logic signed [15:0] m_i,
    output logic signed [15:0] m_q,
    output logic               m_last,
    output logic               busy,
    output logic               err_timeout
);

    localparam int              WCW       = $clog2(TIMEOUT + 1);
    localparam logic [WCW-1:0]  WAIT_LAST = WCW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        C_IDLE  = 2'd0,
        C_START = 2'd1,
        C_WAIT  = 2'd2
    } cstate_t;

    // Natural-order output index n maps to core slot with the 3 index bits reversed.
    function automatic logic [2:0] bitrev3(input logic [2:0] n);
        return {n[0], n[1], n[2]};
    endfunction

    cstate_t                state_q, state_d;
    logic [3:0]             in_cnt_q, in_cnt_d;
    logic [WCW-1:0]         wait_cnt_q, wait_cnt_d;
    logic [2:0]             out_cnt_q, out_cnt_d;
    logic                   out_full_q, out_full_d;
    logic                   err_timeout_q, err_timeout_d;

    logic signed [7:0]      in_i_q  [8];
    logic signed [7:0]      in_i_d  [8];
    logic signed [7:0]      in_q_q  [8];
    logic signed [7:0]      in_q_d  [8];
    logic signed [15:0]     out_i_q [8];
    logic signed [15:0]     out_i_d [8];
    logic signed [15:0]     out_q_q [8];
    logic signed [15:0]     out_q_d [8];

    logic                   s_hs;
    logic                   m_hs;
    logic [2:0]             rd_slot;

    // Input side is open only while the core is idle and the buffer has room;
    // held low while reset is asserted so nothing is accepted during reset.
    assign s_ready     = !rst && (in_cnt_q < 4'd8) && (state_q == C_IDLE);
    assign s_hs        = s_valid && s_ready;
    assign m_valid     = out_full_q;
    assign m_hs        = m_valid && m_ready;
    assign rd_slot     = bitrev3(out_cnt_q);
    assign core_start  = (state_q == C_START);
    assign err_timeout = err_timeout_q;
    assign busy        = (in_cnt_q != 4'd0) || (state_q != C_IDLE) || out_full_q;

    // Output data is forced to zero whenever nothing is being presented.
    assign m_i    = out_full_q ? out_i_q[rd_slot] : 16'sd0;
    assign m_q    = out_full_q ? out_q_q[rd_slot] : 16'sd0;
    assign m_last = out_full_q && (out_cnt_q == 3'd7);

    // Drive the packed core input bus straight from the input buffer.
    always_comb begin
        core_in = '0;
        for (int k = 0; k < 8; k++) begin
            core_in[16*k +: 8]     = in_i_q[k];
            core_in[16*k + 8 +: 8] = in_q_q[k];
        end
    end

    // Next-state logic: input fill, core handshake with watchdog, output drain.
    always_comb begin
        state_d       = state_q;
        in_cnt_d      = in_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        out_cnt_d     = out_cnt_q;
        out_full_d    = out_full_q;
        err_timeout_d = err_timeout_q;
        in_i_d        = in_i_q;
        in_q_d        = in_q_q;
        out_i_d       = out_i_q;
        out_q_d       = out_q_q;

        if (flush) begin
            // Abort everything in flight; the sticky error survives.
            in_cnt_d   = 4'd0;
            out_cnt_d  = 3'd0;
            out_full_d = 1'b0;
            wait_cnt_d = '0;
            state_d    = C_IDLE;
        end else begin
            if (s_hs) begin
                in_i_d[in_cnt_q[2:0]] = s_i;
                in_q_d[in_cnt_q[2:0]] = s_q;
                in_cnt_d              = in_cnt_q + 4'd1;
            end

            if (m_hs) begin
                if (out_cnt_q == 3'd7) begin
                    out_full_d = 1'b0;
                    out_cnt_d  = 3'd0;
                end else begin
                    out_cnt_d = out_cnt_q + 3'd1;
                end
            end

            case (state_q)
                C_IDLE: begin
                    // Wait for a full symbol and room to hold its results.
                    if ((in_cnt_q == 4'd8) && !out_full_q) begin
                        state_d = C_START;
                    end
                end
                C_START: begin
                    state_d    = C_WAIT;
                    wait_cnt_d = '0;
                end
                C_WAIT: begin
                    if (core_done) begin
                        for (int k = 0; k < 8; k++) begin
                            out_i_d[k] = core_out[32*k +: 16];
                            out_q_d[k] = core_out[32*k + 16 +: 16];
                        end
                        out_full_d = 1'b1;
                        in_cnt_d   = 4'd0;
                        state_d    = C_IDLE;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        // Core never answered: drop the symbol and flag it.
                        err_timeout_d = 1'b1;
                        in_cnt_d      = 4'd0;
                        state_d       = C_IDLE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
                default: state_d = C_IDLE;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= C_IDLE;
            in_cnt_q      <= 4'd0;
            wait_cnt_q    <= '0;
            out_cnt_q     <= 3'd0;
            out_full_q    <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            in_cnt_q      <= in_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            out_cnt_q     <= out_cnt_d;
            out_full_q    <= out_full_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    // Input sample buffer; cleared on reset so core_in comes up as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 8; k++) begin
                in_i_q[k] <= 8'sd0;
                in_q_q[k] <= 8'sd0;
            end
        end else begin
            in_i_q <= in_i_d;
            in_q_q <= in_q_d;
        end
    end

    // Result buffer in core slot order; its outputs are masked while empty.
    always_ff @(posedge clk) begin
        out_i_q <= out_i_d;
        out_q_q <= out_q_d;
    end

endmodule

// File: tb/tb_ifft8_symbol_ctrl.sv
// Testbench for ifft8_symbol_ctrl: randomized stream stimulus, a behavioural
// IFFT core model that feeds an expected-output queue, and a monitor that pops
// and compares every delivered output sample.
module tb_ifft8_symbol_ctrl;

    localparam int TO = 16;

    logic               clk;
    logic               rst;
    logic               flush;
    logic               s_valid;
    logic               s_ready;
    logic signed [7:0]  s_i;
    logic signed [7:0]  s_q;
    logic               core_start;
    logic [127:0]       core_in;
    logic               core_done;
    logic [255:0]       core_out;
    logic               m_valid;
    logic               m_ready;
    logic signed [15:0] m_i;
    logic signed [15:0] m_q;
    logic               m_last;
    logic               busy;
    logic               err_timeout;

    ifft8_symbol_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_i(s_i), .s_q(s_q),
        .core_start(core_start), .core_in(core_in),
        .core_done(core_done), .core_out(core_out),
        .m_valid(m_valid), .m_ready(m_ready), .m_i(m_i), .m_q(m_q),
        .m_last(m_last), .busy(busy), .err_timeout(err_timeout)
    );

    typedef struct {
        logic [15:0] i;
        logic [15:0] q;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    logic [16:0] log_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_start = 0, n_done = 0, n_pop = 0;
    int start_cyc = -100, done_cyc = -100, mlast_hs_cyc = -100, last_in_hs_cyc = -100;
    int core_lat = 5;
    int rdy_mode = 0;
    bit core_respond = 1;
    bit dir_out = 0;
    bit inject_done = 0;

    logic signed [7:0] sym_i [8];
    logic signed [7:0] sym_q [8];
    logic signed [7:0] exp_in_i [8];
    logic signed [7:0] exp_in_q [8];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Downstream ready generator: 0 always, 1 pattern 1,0,0,1, 2 random, 3 held low.
    initial begin
        int pc;
        pc = 0;
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0: m_ready = 1'b1;
                1: begin
                    m_ready = ((pc % 4) == 0) || ((pc % 4) == 3);
                    pc++;
                end
                2: m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b0;
            endcase
        end
    end

    // Behavioural IFFT core: checks the parallel inputs, answers after core_lat
    // cycles, and queues the expected natural-order output stream.
    initial begin
        logic [127:0] want_in;
        logic [255:0] vec;
        logic [15:0]  oi [8];
        logic [15:0]  oq [8];
        exp_t         e;
        int           s;
        core_done = 1'b0;
        core_out  = '0;
        forever begin
            @(negedge clk);
            if (!rst && core_start === 1'b1) begin
                start_cyc = cyc;
                n_start++;
                for (int k = 0; k < 8; k++) begin
                    want_in[16*k +: 8]     = exp_in_i[k];
                    want_in[16*k + 8 +: 8] = exp_in_q[k];
                end
                chk("core_in", core_in, want_in);
                if (core_respond) begin
                    for (int k = 0; k < 8; k++) begin
                        if (dir_out) begin
                            oi[k] = 16'(100 + k);
                            oq[k] = 16'(-100 - k);
                        end else begin
                            oi[k] = 16'($urandom);
                            oq[k] = 16'($urandom);
                        end
                        vec[32*k +: 16]      = oi[k];
                        vec[32*k + 16 +: 16] = oq[k];
                    end
                    repeat (core_lat) @(posedge clk);
                    #1;
                    core_done = 1'b1;
                    core_out  = vec;
                    done_cyc  = cyc;
                    n_done++;
                    for (int n = 0; n < 8; n++) begin
                        s      = (n % 2) * 4 + ((n / 2) % 2) * 2 + (n / 4);
                        e.i    = oi[s];
                        e.q    = oq[s];
                        e.last = (n == 7);
                        exp_q.push_back(e);
                    end
                    @(posedge clk);
                    #1;
                    core_done = 1'b0;
                end
            end else if (inject_done) begin
                @(posedge clk);
                #1;
                core_done = 1'b1;
                core_out  = {8{32'($urandom)}};
                @(posedge clk);
                #1;
                core_done = 1'b0;
            end
        end
    end

    // Output monitor: scoreboard pops, stall stability, start pulse width, done->valid latency.
    initial begin
        bit   stalled, prev_vld, prev_cs;
        logic [32:0] held;
        exp_t e;
        stalled = 0; prev_vld = 0; prev_cs = 0; held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 0; prev_vld = 0; prev_cs = 0;
                continue;
            end
            if (core_start) chk("start_pulse_width", 128'(prev_cs), 128'(0));
            prev_cs = core_start;
            if (m_valid && !prev_vld) begin
                chk("done_to_valid", 128'(cyc), 128'(done_cyc + 1));
                chk("s_ready_after_done", 128'(s_ready), 128'(1));
            end
            if (stalled) chk("stall_hold", 128'({m_valid, m_i, m_q, m_last}), 128'({1'b1, held}));
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 128'({m_i, m_q, m_last}), 128'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("m_sample", 128'({m_i, m_q, m_last}), 128'({e.i, e.q, e.last}));
                end
                log_q.push_back({m_i, m_last});
                n_pop++;
                if (m_last) mlast_hs_cyc = cyc;
                stalled = 0;
            end else if (m_valid) begin
                stalled = 1;
                held    = {m_i, m_q, m_last};
            end else begin
                stalled = 0;
            end
            prev_vld = m_valid;
        end
    end

    // Push n samples from sym_i/sym_q with optional random idle gaps.
    task automatic send_sym(input int n, input int max_gap);
        bit ok;
        for (int j = 0; j < n; j++) begin
            if (max_gap > 0) begin
                s_valid = 1'b0;
                repeat ($urandom_range(0, max_gap)) begin
                    @(posedge clk);
                    #1;
                end
            end
            s_valid = 1'b1;
            s_i     = sym_i[j];
            s_q     = sym_q[j];
            ok      = 0;
            for (int t = 0; t < 300; t++) begin
                @(negedge clk);
                if (s_ready) begin
                    ok = 1;
                    last_in_hs_cyc = cyc;
                    @(posedge clk);
                    #1;
                    break;
                end
                @(posedge clk);
                #1;
            end
            if (!ok) chk("s_ready_timeout", 128'(0), 128'(1));
        end
        s_valid = 1'b0;
        if (n == 8) begin
            exp_in_i = sym_i;
            exp_in_q = sym_q;
        end
    endtask

    task automatic rand_sym();
        for (int k = 0; k < 8; k++) begin
            sym_i[k] = 8'($urandom);
            sym_q[k] = 8'($urandom);
        end
    endtask

    task automatic wait_start(input int base);
        bit ok;
        ok = 0;
        for (int t = 0; t < 100; t++) begin
            if (n_start > base) begin
                ok = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) chk("core_start_timeout", 128'(0), 128'(1));
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int t = 0; t < 3000; t++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !busy && !m_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 128'(0), 128'(1));
    endtask

    initial begin
        int base, base_done, pop_base, viol, err_cyc;
        int want_seq [8];
        want_seq = '{100, 104, 102, 106, 101, 105, 103, 107};
        rst = 1'b1; flush = 1'b0; s_valid = 1'b0; s_i = '0; s_q = '0;

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", 128'(s_ready), 128'(0));
        chk("rst_m_out", 128'({m_valid, m_last, m_i, m_q}), 128'(0));
        chk("rst_core", 128'({core_start, core_in}), 128'(0));
        chk("rst_busy_err", 128'({busy, err_timeout}), 128'(0));
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("s_ready_after_rst", 128'(s_ready), 128'(1));
        @(posedge clk); #1;

        // Directed symbol (k,-k), core answers (100+k,-100-k) after 5 cycles.
        for (int k = 0; k < 8; k++) begin
            sym_i[k] = 8'(k);
            sym_q[k] = 8'(-k);
        end
        dir_out = 1; core_lat = 5; base = n_start; pop_base = n_pop;
        send_sym(8, 0);
        wait_start(base);
        chk("load_to_start", 128'(start_cyc), 128'(last_in_hs_cyc + 2));
        chk("core_in_slot3", 128'(core_in[63:48]), 128'(16'hFD03));
        wait_idle();
        chk("one_start_pulse", 128'(n_start - base), 128'(1));
        for (int k = 0; k < 8; k++) begin
            if (log_q.size() > pop_base + k)
                chk("directed_order", 128'(log_q[pop_base + k]), 128'({16'(want_seq[k]), 1'(k == 7)}));
            else
                chk("directed_count", 128'(log_q.size()), 128'(pop_base + 8));
        end
        dir_out = 0;

        // Backpressure with ready pattern 1,0,0,1.
        rdy_mode = 1;
        rand_sym();
        send_sym(8, 1);
        wait_idle();

        // Overlap: second symbol loaded while the first drains.
        rand_sym();
        send_sym(8, 0);
        rand_sym();
        send_sym(8, 0);
        base_done = n_done; base = n_start; viol = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (s_ready) viol++;
            if (n_done != base_done) break;
        end
        chk("ovl_s_ready_low", 128'(viol), 128'(0));
        chk("ovl_start_count", 128'(n_start), 128'(base + 1));
        chk("ovl_start_after_mlast", 128'(start_cyc), 128'(mlast_hs_cyc + 2));
        @(negedge clk);
        chk("ovl_s_ready_after_done", 128'(s_ready), 128'(1));
        wait_idle();
        rdy_mode = 0;

        // Watchdog: core never answers.
        chk("err_clear_before_wd", 128'(err_timeout), 128'(0));
        core_respond = 0; base = n_start; err_cyc = -1;
        rand_sym();
        send_sym(8, 0);
        wait_start(base);
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (err_timeout) begin
                err_cyc = cyc;
                break;
            end
        end
        chk("wd_err_cycle", 128'(err_cyc), 128'(start_cyc + TO + 1));
        chk("wd_s_ready", 128'(s_ready), 128'(1));
        chk("wd_no_m_valid", 128'(m_valid), 128'(0));
        @(posedge clk); #1;
        core_respond = 1;
        rand_sym();
        send_sym(8, 0);
        wait_idle();
        chk("wd_err_sticky", 128'(err_timeout), 128'(1));

        // Flush mid-load, then a stray core_done.
        rand_sym();
        pop_base = n_pop;
        send_sym(5, 0);
        flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        @(negedge clk);
        chk("flush_idle", 128'({busy, s_ready}), 128'({1'b0, 1'b1}));
        @(posedge clk); #1;
        inject_done = 1;
        repeat (3) @(posedge clk);
        #1; inject_done = 0;
        repeat (10) @(posedge clk);
        #1;
        chk("flush_no_output", 128'({n_pop, m_valid, busy}), 128'({pop_base, 1'b0, 1'b0}));
        chk("flush_err_kept", 128'(err_timeout), 128'(1));
        rand_sym();
        send_sym(8, 0);
        wait_idle();

        // Reset in the middle of unload, at out_cnt == 3.
        core_lat = 5; rdy_mode = 0; pop_base = n_pop;
        rand_sym();
        send_sym(8, 0);
        for (int t = 0; t < 200; t++) begin
            @(posedge clk); #1;
            if (n_pop >= pop_base + 3) break;
        end
        rdy_mode = 3; rst = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_m_out", 128'({m_valid, m_last, m_i, m_q}), 128'(0));
        chk("midrst_ctrl", 128'({core_start, busy, s_ready, err_timeout}), 128'(0));
        chk("midrst_pops", 128'(n_pop), 128'(pop_base + 3));
        @(posedge clk); #1; rst = 1'b0; rdy_mode = 0;
        @(negedge clk);
        chk("midrst_s_ready", 128'(s_ready), 128'(1));
        @(posedge clk); #1;
        rand_sym();
        send_sym(8, 0);
        wait_idle();

        // Randomized traffic: random gaps, latency and ready.
        rdy_mode = 2;
        for (int r = 0; r < 8; r++) begin
            core_lat = $urandom_range(1, 10);
            rand_sym();
            send_sym(8, 2);
        end
        wait_idle();
        chk("final_queue_empty", 128'(exp_q.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL global_timeout actual=%0d required=finish", cyc);
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/ifft8_symbol_ctrl.md
# ifft8_symbol_ctrl

Sequencer for the 8-point IFFT core. It collects one OFDM symbol of 8 complex 8-bit subcarrier samples from a valid/ready stream and presents them to the core in parallel. It then pulses the core start, waits for the core's done pulse, and captures the 8 bit-reversed 16-bit results. Finally it streams the results out in natural time order with valid/ready. The block sits between the subcarrier mapper and the cyclic-prefix/TX stage and owns the core's handshake, watchdog and output reordering.

## Interface
- TIMEOUT, 64: max cycles in WAIT before the symbol is abandoned (≥2); wait counter is $clog2(TIMEOUT+1) bits.
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous abort; drops all symbol data, keeps err_timeout.
- s_valid  in  1  input sample valid.
- s_ready  out  1  input sample accepted when s_valid && s_ready.
- s_i, s_q  in  8 each  signed subcarrier sample.
- core_start  out  1  one-cycle start pulse to IFFT core.
- core_in  out  128  packed core inputs; slot k: i=[16k+7:16k], q=[16k+15:16k+8].
- core_done  in  1  core result-valid pulse.
- core_out  in  256  packed core outputs; slot k: i=[32k+15:32k], q=[32k+31:32k+16].
- m_valid  out  1  output sample valid.
- m_ready  in  1  downstream accept.
- m_i, m_q  out  16 each  signed time-domain sample.
- m_last  out  1  high with the 8th sample of a symbol.
- busy  out  1  high when any of in_cnt, core FSM or output buffer is non-idle.
- err_timeout  out  1  sticky watchdog error; cleared only by rst.

## Operation
- Input buffer: 8×(8+8) registers, in_cnt 0..8; accepted sample n goes to slot n. core_in is driven directly from the buffer.
- s_ready = (in_cnt<8) && core FSM in C_IDLE (combinational from registers). Loading the next symbol is allowed while the output side drains.
- Core FSM states:
  - C_IDLE→C_START when in_cnt==8 && out buffer empty.
  - C_START: core_start=1 for exactly one cycle, then →C_WAIT with wait_cnt=0.
  - C_WAIT:
    - On core_done: capture core_out into the output buffer, set out_full, clear in_cnt, →C_IDLE.
    - Otherwise, if wait_cnt==TIMEOUT-1: set err_timeout, clear in_cnt (symbol dropped), →C_IDLE.
    - Otherwise wait_cnt++.
    - core_done wins over timeout in the same cycle.
- core_done outside C_WAIT is ignored.
- Output buffer: 8×(16+16) registers, out_cnt 0..7.
  - m_valid = out_full.
  - Sample n is core slot bitrev3(n), i.e. order 0,4,2,6,1,5,3,7.
  - m_last = (out_cnt==7).
  - On handshake, out_cnt++. After the handshake on n=7, out_full=0 and out_cnt=0.
- m_i/m_q/m_last stay stable while m_valid && !m_ready. There is no arithmetic on the data path: widths pass through unchanged.
- Precedence: rst > flush > normal.
  - flush clears in_cnt, out_cnt, out_full, wait_cnt and FSM to C_IDLE, and deasserts core_start.
  - Buffer contents need not be cleared on flush.

## Timing
- Reset values:
  - s_ready=0 during rst, 1 the cycle after.
  - m_valid=0, m_last=0, m_i=m_q=0.
  - core_start=0, core_in=0, busy=0, err_timeout=0.
- The 8th input handshake at edge T gives in_cnt==8 after T. With the output buffer empty, core_start=1 in the cycle after T+1 (1 cycle in C_IDLE evaluation, 1 in C_START).
- core_done high in cycle D gives m_valid=1 and s_ready=1 in cycle D+1.
- Unload takes 8 cycles minimum with m_ready held high. The next core_start occurs at the earliest 2 cycles after the handshake on the m_last sample.
- Timeout: with core_start in cycle S, err_timeout rises in cycle S+TIMEOUT+1 if no core_done has arrived.
- Throughput: one symbol per max(8 load, 8 unload) + core latency + 3 cycles.

## Test plan
- After reset, load samples (k,−k) for k=0..7. The core model returns slot k = (100+k, −100−k) 5 cycles after start. Expect: exactly one core_start pulse; core_in slot 3 = (3,−3); m sequence i = 100,104,102,106,101,105,103,107; m_last only on 107.
- Backpressure: m_ready pattern 1,0,0,1 repeating. Each sample is held stable while stalled, there is no duplicate or skip, and m_last is on the 8th.
- Overlap: the second symbol is fully loaded during unload of the first. core_start for symbol 2 occurs exactly 2 cycles after the m_last handshake of symbol 1, and s_ready=0 from in_cnt==8 until symbol-2 core_done+1.
- Watchdog: TIMEOUT=16, core_done never asserted. err_timeout=1 at S+17, s_ready=1 again, no m_valid. A following good symbol completes normally and err_timeout stays 1.
- Flush mid-load after 5 samples, then a late core_done pulse. No output is produced. A new 8-sample symbol is processed with correct order and no residue from the aborted one.
- rst asserted mid-unload at out_cnt=3. All outputs go to reset values the next cycle and no m_last is emitted. A subsequent symbol is correct.
